fetch_branch_seq: RTL and testbench



---
 rtl/fetch_branch_seq.sv | 92 +++++++++
 tb/tb_fetch_branch_seq.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fetch_branch_seq.sv
// Instruction fetch/issue sequencer: fetches words over a req/valid handshake,
// issues them to the decoder and resolves BEQ/BNE to advance the PC.
module fetch_branch_seq #(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_valid,
    output logic [31:0]     instr,
    output logic [5:0]      opcode,
    output logic            instr_valid,
    input  logic            Br,
    input  logic            ZeroCheck,
    input  logic            alu_zero,
    input  logic            ex_done,
    output logic [PC_W-1:0] pc,
    output logic            branch_taken
);

    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, WAIT_EX} state_t;

    state_t          state;
    logic [31:0]     ir;
    logic            taken;
    logic [PC_W-1:0] offset;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] pc_next;

    assign instr     = ir;
    assign opcode    = ir[31:26];
    assign imem_addr = pc;

    // opcode[0] distinguishes BNE from BEQ, inverting the zero-flag sense
    always_comb begin
        taken   = Br & ZeroCheck & (alu_zero ^ ir[26]);
        offset  = {{(PC_W-16){ir[15]}}, ir[15:0]} << 2;
        pc_seq  = pc + PC_W'(4);
        pc_next = taken ? pc_seq + offset : pc_seq;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            ir           <= '0;
            imem_req     <= 1'b0;
            instr_valid  <= 1'b0;
            branch_taken <= 1'b0;
        end else begin
            branch_taken <= 1'b0;
            case (state)
                IDLE: begin
                    if (run) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                FETCH: begin
                    if (imem_valid) begin
                        ir          <= imem_rdata;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    instr_valid <= 1'b0;
                    state       <= WAIT_EX;
                end
                WAIT_EX: begin
                    if (ex_done) begin
                        pc           <= pc_next;
                        branch_taken <= taken;
                        if (run) begin
                            state    <= FETCH;
                            imem_req <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_branch_seq.sv
// Self-checking bench for fetch_branch_seq: directed and randomized
// instructions checked against an arithmetic PC/branch model.
module tb_fetch_branch_seq;

    logic        clk = 1'b0;
    logic        rst, run, imem_valid, Br, ZeroCheck, alu_zero, ex_done;
    logic [31:0] imem_rdata, imem_addr, instr, pc;
    logic [5:0]  opcode;
    logic        imem_req, instr_valid, branch_taken;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] exp_pc;

    fetch_branch_seq #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
        .Br(Br), .ZeroCheck(ZeroCheck), .alu_zero(alu_zero),
        .ex_done(ex_done), .pc(pc), .branch_taken(branch_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting in the fetch state; waits are in cycles.
    task automatic do_instr(input logic [31:0] word, input logic br, input logic zc,
                            input logic az, input int fw, input int ew, input logic run_after);
        logic        tk;
        logic signed [15:0] imm;
        int          off;
        for (int i = 0; i < fw; i++) begin
            chk("stall_req", imem_req, 1'b1);
            chk("stall_addr", imem_addr, exp_pc);
            imem_valid = 1'b0;
            ex_done    = 1'($urandom_range(0, 1));
            tick();
        end
        chk("fetch_req", imem_req, 1'b1);
        chk("fetch_addr", imem_addr, exp_pc);
        imem_valid = 1'b1;
        imem_rdata = word;
        ex_done    = 1'b0;
        tick();
        chk("issue_valid", instr_valid, 1'b1);
        chk("issue_req", imem_req, 1'b0);
        chk("issue_instr", instr, word);
        chk("issue_opcode", opcode, word[31:26]);
        imem_valid = 1'b0;
        tick();
        chk("wait_valid", instr_valid, 1'b0);
        for (int i = 0; i < ew; i++) begin
            imem_valid = 1'b1;
            imem_rdata = ~word;
            tick();
            chk("wait_ir_hold", instr, word);
            chk("wait_no_taken", branch_taken, 1'b0);
            chk("wait_pc_hold", pc, exp_pc);
        end
        imem_valid = 1'b0;
        ex_done    = 1'b1;
        Br         = br;
        ZeroCheck  = zc;
        alu_zero   = az;
        run        = run_after;
        tk  = br && zc && (az != word[26]);
        imm = word[15:0];
        off = imm;
        exp_pc = exp_pc + 32'd4 + (tk ? 32'(off * 4) : 32'd0);
        tick();
        ex_done = 1'b0;
        Br = 1'b0; ZeroCheck = 1'b0; alu_zero = 1'b0;
        chk("ex_taken", branch_taken, tk);
        chk("ex_pc", pc, exp_pc);
        chk("ex_next_req", imem_req, run_after);
    endtask

    initial begin
        logic [31:0] r, w;
        logic [5:0]  op;
        rst = 1'b1; run = 1'b1; imem_valid = 1'b0; imem_rdata = '0;
        Br = 1'b0; ZeroCheck = 1'b0; alu_zero = 1'b0; ex_done = 1'b0;
        exp_pc = 32'h0;
        tick(); tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_opcode", opcode, 6'h0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_taken", branch_taken, 1'b0);
        rst = 1'b0;
        tick();

        // sequential R-type, BEQ taken/not taken, BNE taken
        do_instr(32'h0000_0020, 0, 0, 0, 0, 0, 1);
        do_instr(32'h0000_0020, 0, 0, 0, 0, 0, 1);
        do_instr(32'h1000_FFFE, 1, 1, 1, 0, 0, 1);
        chk("beq_taken_pc", pc, 32'd4);
        do_instr(32'h1000_FFFE, 1, 1, 0, 0, 0, 1);
        do_instr(32'h0000_0020, 0, 0, 0, 0, 0, 1);
        do_instr(32'h0000_0020, 1, 0, 1, 0, 0, 1);
        do_instr(32'h1400_0003, 1, 1, 0, 0, 0, 1);
        chk("bne_taken_pc", pc, 32'd32);
        // stall in fetch with stray ex_done, stray imem_valid in wait
        do_instr(32'h0000_0020, 0, 0, 0, 5, 3, 1);

        // reset mid-fetch; late imem_valid must be ignored
        chk("pre_abort_req", imem_req, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_req", imem_req, 1'b0);
        chk("abort_pc", pc, 32'h0);
        chk("abort_instr", instr, 32'h0);
        imem_valid = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("abort_late_valid", instr, 32'h0);
        imem_valid = 1'b0;
        rst = 1'b0;
        exp_pc = 32'h0;
        tick();

        // wrap through the top of the address space
        do_instr(32'h1000_FFFE, 1, 1, 1, 0, 0, 1);
        chk("wrap_top", pc, 32'hFFFF_FFFC);
        do_instr(32'h0000_0020, 0, 0, 0, 0, 0, 1);
        chk("wrap_zero", pc, 32'h0);

        for (int n = 0; n < 40; n++) begin
            r = $urandom();
            case (r[31:30])
                2'd0: op = 6'h04;
                2'd1: op = 6'h05;
                2'd2: op = 6'h00;
                default: op = r[29:24];
            endcase
            w = $urandom();
            w = {op, w[25:0]};
            do_instr(w, r[0], r[1], r[2], int'(r[5:4]), int'(r[7:6]), 1);
        end

        // drop run in WAIT_EX: finish, park in IDLE, then restart
        do_instr(32'h0000_0020, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("park_req", imem_req, 1'b0);
            chk("park_pc", pc, exp_pc);
        end
        run = 1'b1;
        tick();
        chk("restart_req", imem_req, 1'b1);
        chk("restart_addr", imem_addr, exp_pc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
